uart_rx_deframer: RTL and testbench

UART receiver that deframes an asynchronous serial line into parallel payload words. It samples 8-N-1 style frames at mid-bit and presents each word with a one-cycle valid strobe. Framing-error and break conditions are flagged. It is the receive-side counterpart of the board UART link and feeds host command parsing.

---
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx_deframer.sv | 103 ++++++++++
 tb/tb_uart_rx_deframer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side UART pins and deframed word/strobe bundle
// master drives the line and enable and observes results; slave is the deframer.
interface uart_rx_if #(parameter int PAYLOAD_BITS = 8);
  logic uart_rxd;
  logic uart_rx_en;
  logic uart_rx_valid;
  logic [PAYLOAD_BITS-1:0] uart_rx_data;
  logic uart_rx_frame_err;
  logic uart_rx_break;
  modport master (
    output uart_rxd, uart_rx_en,
    input  uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );
  modport slave (
    input  uart_rxd, uart_rx_en,
    output uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: mid-bit sampling UART receiver producing parallel words
// Ports: clk, resetn (async active-low), rx (uart_rx_if.slave): uart_rxd line,
// uart_rx_en start gate, uart_rx_valid/uart_rx_data word, uart_rx_frame_err and
// uart_rx_break one-cycle error strobes.
module uart_rx_deframer #(
  parameter int PAYLOAD_BITS = 8,
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50000000,
  parameter int STOP_BITS    = 1
) (
  input logic      clk,
  input logic      resetn,
  uart_rx_if.slave rx
);
  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = 1 + $clog2(CPB);
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8 || STOP_BITS < 1 || CPB < 2) begin : g_bad_param
    $error("uart_rx_deframer: unsupported parameter set");
  end
  typedef enum logic [2:0] {IDLE, START, RECV, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [PAYLOAD_BITS-1:0] sreg, sreg_n, data, data_n;
  logic valid, valid_n, ferr, ferr_n, brk, brk_n;
  logic rxd_s, half, full;
  assign rxd_s = sync[1];
  assign half = cnt == CW'(HALF - 1);
  assign full = cnt == CW'(CPB - 1);
  assign rx.uart_rx_valid = valid;
  assign rx.uart_rx_data = data;
  assign rx.uart_rx_frame_err = ferr;
  assign rx.uart_rx_break = brk;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sreg <= '0;
      data <= '0;
      valid <= 1'b0;
      ferr <= 1'b0;
      brk <= 1'b0;
    end else begin
      sync <= {sync[0], rx.uart_rxd};
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sreg <= sreg_n;
      data <= data_n;
      valid <= valid_n;
      ferr <= ferr_n;
      brk <= brk_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    sreg_n = sreg;
    data_n = data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
    brk_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_cnt_n = '0;
        state_n = (!rxd_s && rx.uart_rx_en) ? START : IDLE;
      end
      START: if (half) begin
        cnt_n = '0;
        state_n = rxd_s ? IDLE : RECV;
      end
      RECV: if (full) begin
        cnt_n = '0;
        sreg_n = {rxd_s, sreg[PAYLOAD_BITS-1:1]};
        bit_cnt_n = bit_cnt + 1'b1;
        state_n = (bit_cnt == 4'(PAYLOAD_BITS - 1)) ? STOP : RECV;
      end
      // Returning to IDLE at mid-stop lets a following start edge be caught with no gap.
      STOP: if (full) begin
        cnt_n = '0;
        valid_n = rxd_s;
        ferr_n = !rxd_s;
        brk_n = !rxd_s && sreg == '0;
        data_n = rxd_s ? sreg : data;
        state_n = rxd_s ? IDLE : WAIT_HIGH;
      end
      // A line held low must go high before another start can be accepted.
      WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rxd_s ? IDLE : WAIT_HIGH;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
  localparam int CPB = 50;
  localparam int LAT = 2 + 25 + 8 * 50 + 50 + 1;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #10 clk = ~clk;
  uart_rx_if #(.PAYLOAD_BITS(8)) u();
  uart_rx_deframer #(
    .PAYLOAD_BITS(8),
    .BIT_RATE(1000000),
    .CLK_HZ(50000000),
    .STOP_BITS(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(u.slave)
  );
  int checks = 0, errors = 0;
  int cyc = 0, n_valid = 0, n_ferr = 0, n_brk = 0, last_valid = 0;
  int exp_valid = 0, exp_ferr = 0, exp_brk = 0;
  logic [7:0] rx_q[$], exp_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (u.uart_rx_valid === 1'b1) begin
      rx_q.push_back(u.uart_rx_data);
      n_valid++;
      last_valid = cyc;
    end
    if (u.uart_rx_frame_err === 1'b1) n_ferr++;
    if (u.uart_rx_break === 1'b1) n_brk++;
  end
  function automatic void model(logic [7:0] d, bit stop);
    if (stop) begin
      exp_q.push_back(d);
      exp_valid++;
    end else begin
      exp_ferr++;
      if (d == 8'h00) exp_brk++;
    end
  endfunction
  task automatic wait_bits(int n);
    repeat (n * CPB) @(negedge clk);
  endtask
  task automatic send_frame(logic [7:0] d, bit stop, int nstop);
    if (u.uart_rx_en) model(d, stop);
    u.uart_rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      u.uart_rxd = d[i];
      wait_bits(1);
    end
    u.uart_rxd = stop;
    wait_bits(1);
    u.uart_rxd = 1'b1;
    wait_bits(nstop - 1);
  endtask
  task automatic test_counts(string tag);
    checks++;
    if (n_valid !== exp_valid) begin errors++; $display("FAIL %s valid_count: got %0d expected %0d", tag, n_valid, exp_valid); end
    checks++;
    if (n_ferr !== exp_ferr) begin errors++; $display("FAIL %s frame_err_count: got %0d expected %0d", tag, n_ferr, exp_ferr); end
    checks++;
    if (n_brk !== exp_brk) begin errors++; $display("FAIL %s break_count: got %0d expected %0d", tag, n_brk, exp_brk); end
  endtask
  task automatic test_data(string tag, logic [7:0] e);
    checks++;
    if (u.uart_rx_data !== e) begin errors++; $display("FAIL %s data: got %h expected %h", tag, u.uart_rx_data, e); end
  endtask
  task automatic test_words(string tag);
    logic [7:0] w, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL %s word: got none expected %h", tag, e);
      end else begin
        w = rx_q.pop_front();
        if (w !== e) begin errors++; $display("FAIL %s word: got %h expected %h", tag, w, e); end
      end
    end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL %s extra_words: got %0d expected 0", tag, rx_q.size()); end
    rx_q.delete();
  endtask
  task automatic test_reset;
    u.uart_rxd = 1'b1;
    u.uart_rx_en = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (u.uart_rx_valid !== 1'b0 || u.uart_rx_frame_err !== 1'b0 || u.uart_rx_break !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: got %b%b%b expected 000", u.uart_rx_valid, u.uart_rx_frame_err, u.uart_rx_break); end
    test_data("reset", 8'h00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_bits(1);
    test_counts("reset");
    test_data("reset_release", 8'h00);
  endtask
  task automatic test_single;
    int t0;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1);
    wait_bits(1);
    test_counts("single");
    test_data("single", 8'hA5);
    checks++;
    if (last_valid - t0 < LAT - 1 || last_valid - t0 > LAT + 1)
      begin errors++; $display("FAIL single_latency: got %0d expected %0d+-1", last_valid - t0, LAT); end
    exp_q.delete();
    rx_q.delete();
  endtask
  task automatic test_back_to_back;
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h55, 1'b1, 2);
    wait_bits(1);
    test_words("b2b");
    test_counts("b2b");
  endtask
  task automatic test_glitch;
    u.uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    u.uart_rxd = 1'b1;
    wait_bits(2);
    test_counts("glitch");
    send_frame(8'h3C, 1'b1, 1);
    wait_bits(1);
    test_words("glitch_rx");
    test_data("glitch_rx", 8'h3C);
  endtask
  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 2);
    wait_bits(1);
    test_counts("frame_err");
    test_data("frame_err_hold", 8'h3C);
    send_frame(8'h81, 1'b1, 1);
    wait_bits(1);
    test_words("frame_err_next");
    test_data("frame_err_next", 8'h81);
  endtask
  task automatic test_break;
    u.uart_rxd = 1'b0;
    model(8'h00, 1'b0);
    wait_bits(20);
    test_counts("break_low");
    u.uart_rxd = 1'b1;
    wait_bits(2);
    send_frame(8'h7E, 1'b1, 1);
    wait_bits(1);
    test_words("break_next");
    test_counts("break_next");
    test_data("break_next", 8'h7E);
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h96;
    u.uart_rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      u.uart_rxd = d[i];
      wait_bits(1);
    end
    u.uart_rxd = d[4];
    repeat (CPB / 2) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (u.uart_rx_valid !== 1'b0 || u.uart_rx_frame_err !== 1'b0 || u.uart_rx_break !== 1'b0)
      begin errors++; $display("FAIL midreset_strobes: got %b%b%b expected 000", u.uart_rx_valid, u.uart_rx_frame_err, u.uart_rx_break); end
    test_data("midreset", 8'h00);
    u.uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    wait_bits(12);
    test_counts("midreset");
  endtask
  task automatic test_enable;
    u.uart_rx_en = 1'b0;
    send_frame(8'h5A, 1'b1, 1);
    wait_bits(1);
    test_counts("en_off");
    test_data("en_off", 8'h00);
    u.uart_rx_en = 1'b1;
    fork
      send_frame(8'hC3, 1'b1, 1);
      begin
        wait_bits(3);
        u.uart_rx_en = 1'b0;
      end
    join
    wait_bits(1);
    u.uart_rx_en = 1'b1;
    test_words("en_midframe");
    test_counts("en_midframe");
    test_data("en_midframe", 8'hC3);
  endtask
  task automatic test_random;
    logic [7:0] d;
    bit stop;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      stop = $urandom_range(0, 3) != 0;
      send_frame(d, stop, stop ? int'($urandom_range(1, 2)) : 2);
    end
    wait_bits(1);
    test_words("random");
    test_counts("random");
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_break;
    test_reset_mid_frame;
    test_enable;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
